// File: rtl/approx_adder_tree_pipe_pkg.sv
// Shared definitions for the approximate adder tree.
//   mode_e     : lower-part approximation selector carried with every beat
//   clog2      : elaboration-time ceil(log2) used to size the tree depth
//   approx_add : one adder node, exact or with an approximated lower part
package approx_tree_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,
    MODE_XOR   = 2'b01,
    MODE_OR    = 2'b10,
    MODE_TRUNC = 2'b11
  } mode_e;

  // Operand width used inside approx_add; callers zero-extend into it and
  // size-cast the result back down to their own level width.
  localparam int OPW = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Upper parts are added with the k low bits masked to zero, so no carry can
  // leak from the lower part. k = 0 makes the mask empty and every mode exact.
  function automatic logic [OPW:0] approx_add(input logic [OPW-1:0] x,
                                               input logic [OPW-1:0] y,
                                               input mode_e          mode,
                                               input int             k);
    logic [OPW-1:0] lo_mask;
    logic [OPW-1:0] lo;
    logic [OPW:0]   hi;
    logic [OPW:0]   result;
    lo_mask = (64'd1 << k) - 64'd1;
    hi      = {1'b0, x & ~lo_mask} + {1'b0, y & ~lo_mask};
    case (mode)
      MODE_XOR:   lo = (x ^ y) & lo_mask;
      MODE_OR:    lo = (x | y) & lo_mask;
      MODE_TRUNC: lo = 64'd0;
      default:    lo = 64'd0;
    endcase
    if (mode == MODE_EXACT) begin
      result = {1'b0, x} + {1'b0, y};
    end else begin
      result = hi | {1'b0, lo};
    end
    return result;
  endfunction

endpackage

// File: rtl/approx_adder_tree_pipe_if.sv
// Stream bundle of the adder tree.
//   in_valid/in_ready/in_data/in_mode      : operand beat (producer -> tree)
//   out_valid/out_ready/out_sum/out_mode   : result beat (tree -> consumer)
// master = producer/consumer side, slave = the tree. L must equal log2(N_IN).
interface approx_adder_tree_pipe_if #(
  parameter int N_IN = 8,
  parameter int W    = 8,
  parameter int L    = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN*W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [W+L-1:0]    out_sum;
  logic [1:0]        out_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_mode
  );
endinterface

// File: rtl/approx_adder_tree_pipe_level.sv
// One tree level: N/2 adders on adjacent operand pairs (2j, 2j+1) plus the
// stage register.
//   load_i  : stage may take a new beat this cycle (from the ready chain)
//   valid_i/mode_i/data_i : upstream beat, N operands of WL bits
//   valid_q/mode_q/data_q : registered beat, N/2 sums of WL+1 bits
module approx_tree_level
  import approx_tree_pkg::*;
#(
  parameter int N  = 8,
  parameter int WL = 8,
  parameter int K  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic                      valid_i,
  input  logic [1:0]                mode_i,
  input  logic [N*WL-1:0]           data_i,
  output logic                      valid_q,
  output logic [1:0]                mode_q,
  output logic [(N/2)*(WL+1)-1:0]   data_q
);
  localparam int WO = WL + 1;

  logic                  valid_d;
  logic [1:0]            mode_d;
  logic [(N/2)*WO-1:0]   data_d;

  // Next stage contents: take the upstream beat on load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      // Data and mode only change for a real beat, so bubbles cost no toggling.
      if (valid_i) begin
        mode_d = mode_i;
        for (int j = 0; j < N/2; j++) begin
          data_d[j*WO +: WO] = WO'(approx_add(OPW'(data_i[(2*j)*WL +: WL]),
                                              OPW'(data_i[(2*j+1)*WL +: WL]),
                                              mode_e'(mode_i), K));
        end
      end else begin
        mode_d = mode_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      mode_q  <= 2'b00;
      data_q  <= {((N/2)*WO){1'b0}};
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/approx_adder_tree_pipe.sv
// Pipelined N_IN-input approximate adder tree with a valid/ready stream.
//   clk, rst (async, active-low)
//   bus       : stream bundle (slave side), result latency = log2(N_IN)
//   clr_stats : synchronous clear of the statistics, wins over a transfer
//   err_acc   : saturating sum of (exact - approx) over accepted results
//   beat_cnt  : saturating count of accepted results
module approx_adder_tree_pipe
  import approx_tree_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int W       = 8,
  parameter int K       = 3,
  parameter int ERR_MON = 1,
  parameter int ACC_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  approx_adder_tree_pipe_if.slave  bus,
  input  logic                     clr_stats,
  output logic [ACC_W-1:0]         err_acc,
  output logic [ACC_W-1:0]         beat_cnt
);
  localparam int L  = clog2(N_IN);
  localparam int OW = W + L;

  // Bit offset of level s outputs in the flattened level bus.
  function automatic int lvl_off(input int s);
    int acc;
    acc = 0;
    for (int t = 0; t < s; t++) begin
      acc += (N_IN >> (t + 1)) * (W + t + 1);
    end
    return acc;
  endfunction

  localparam int TOT = lvl_off(L);

  wire  [TOT-1:0] lvl_data;
  wire  [L-1:0]   lvl_valid;
  wire  [2*L-1:0] lvl_mode;
  logic [L-1:0]   load_s;

  // Ready chain: a stage loads when empty or when its successor moves on.
  always_comb begin
    load_s        = {L{1'b0}};
    load_s[L-1]   = !lvl_valid[L-1] || bus.out_ready;
    for (int s = L - 2; s >= 0; s--) begin
      load_s[s] = !lvl_valid[s] || load_s[s+1];
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_lvl
    localparam int NI = N_IN >> s;
    localparam int WI = W + s;
    wire [NI*WI-1:0] din;
    wire             vin;
    wire [1:0]       min;
    if (s == 0) begin : g_src_in
      assign din = bus.in_data;
      assign vin = bus.in_valid;
      assign min = bus.in_mode;
    end else begin : g_src_lvl
      assign din = lvl_data[lvl_off(s-1) +: NI*WI];
      assign vin = lvl_valid[s-1];
      assign min = lvl_mode[2*(s-1) +: 2];
    end
    approx_tree_level #(.N(NI), .WL(WI), .K(K)) u_level (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_s[s]),
      .valid_i (vin),
      .mode_i  (min),
      .data_i  (din),
      .valid_q (lvl_valid[s]),
      .mode_q  (lvl_mode[2*s +: 2]),
      .data_q  (lvl_data[lvl_off(s) +: (NI/2)*(WI+1)])
    );
  end

  assign bus.in_ready  = load_s[0];
  assign bus.out_valid = lvl_valid[L-1];
  assign bus.out_sum   = lvl_data[lvl_off(L-1) +: OW];
  assign bus.out_mode  = lvl_mode[2*(L-1) +: 2];

  if (ERR_MON != 0) begin : g_mon
    // Shadow exact tree: same loads and valids as the main tree, data only.
    wire [TOT-1:0] sh_data;
    for (genvar s = 0; s < L; s++) begin : g_sh
      localparam int NI = N_IN >> s;
      localparam int WI = W + s;
      localparam int WO = WI + 1;
      wire [NI*WI-1:0]       din;
      wire                   vin;
      logic [(NI/2)*WO-1:0]  sh_d;
      logic [(NI/2)*WO-1:0]  sh_q;
      if (s == 0) begin : g_src_in
        assign din = bus.in_data;
        assign vin = bus.in_valid;
      end else begin : g_src_lvl
        assign din = sh_data[lvl_off(s-1) +: NI*WI];
        assign vin = lvl_valid[s-1];
      end
      // Exact pairwise sums, captured alongside the main stage.
      always_comb begin
        sh_d = sh_q;
        if (load_s[s] && vin) begin
          for (int j = 0; j < NI/2; j++) begin
            sh_d[j*WO +: WO] = WO'(approx_add(OPW'(din[(2*j)*WI +: WI]),
                                              OPW'(din[(2*j+1)*WI +: WI]),
                                              MODE_EXACT, 0));
          end
        end else begin
          sh_d = sh_q;
        end
      end
      // Shadow stage register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sh_q <= {((NI/2)*WO){1'b0}};
        end else begin
          sh_q <= sh_d;
        end
      end
      assign sh_data[lvl_off(s) +: (NI/2)*WO] = sh_q;
    end

    logic [ACC_W-1:0] err_d, err_q, cnt_d, cnt_q;
    logic [OW-1:0]    diff_s;
    logic [ACC_W:0]   err_sum_s, cnt_sum_s;
    logic             fire_s;

    // Statistics update; approx never exceeds exact so diff_s is non-negative.
    always_comb begin
      fire_s    = bus.out_valid && bus.out_ready;
      diff_s    = sh_data[lvl_off(L-1) +: OW] - bus.out_sum;
      err_sum_s = {1'b0, err_q} + (ACC_W+1)'(diff_s);
      cnt_sum_s = {1'b0, cnt_q} + {{ACC_W{1'b0}}, 1'b1};
      err_d     = err_q;
      cnt_d     = cnt_q;
      if (clr_stats) begin
        err_d = {ACC_W{1'b0}};
        cnt_d = {ACC_W{1'b0}};
      end else if (fire_s) begin
        err_d = err_sum_s[ACC_W] ? {ACC_W{1'b1}} : err_sum_s[ACC_W-1:0];
        cnt_d = cnt_sum_s[ACC_W] ? {ACC_W{1'b1}} : cnt_sum_s[ACC_W-1:0];
      end else begin
        err_d = err_q;
        cnt_d = cnt_q;
      end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        err_q <= {ACC_W{1'b0}};
        cnt_q <= {ACC_W{1'b0}};
      end else begin
        err_q <= err_d;
        cnt_q <= cnt_d;
      end
    end

    assign err_acc  = err_q;
    assign beat_cnt = cnt_q;
  end else begin : g_no_mon
    assign err_acc  = {ACC_W{1'b0}};
    assign beat_cnt = {ACC_W{1'b0}};
  end
endmodule

// File: tb/tb_approx_adder_tree_pipe.sv
module tb_approx_adder_tree_pipe;
  localparam int N_IN  = 8;
  localparam int W     = 8;
  localparam int K     = 3;
  localparam int ACC_W = 32;
  localparam int L     = 3;
  localparam longint SAT = (longint'(1) << ACC_W) - 1;

  typedef struct {
    longint     sum;
    longint     exact;
    logic [1:0] mode;
    int         acc_cyc;
    int         stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_stats = 1'b0;
  logic [ACC_W-1:0] err_acc, beat_cnt, err_acc0, beat_cnt0;

  approx_adder_tree_pipe_if #(.N_IN(N_IN), .W(W), .L(L)) bus ();
  approx_adder_tree_pipe_if #(.N_IN(N_IN), .W(W), .L(L)) bus0 ();

  approx_adder_tree_pipe #(.N_IN(N_IN), .W(W), .K(K), .ERR_MON(1), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_stats(clr_stats),
    .err_acc(err_acc), .beat_cnt(beat_cnt));

  // K=0 build fed with every beat the main tree accepts; never stalls.
  approx_adder_tree_pipe #(.N_IN(N_IN), .W(W), .K(0), .ERR_MON(1), .ACC_W(ACC_W)) dut_k0 (
    .clk(clk), .rst(rst), .bus(bus0), .clr_stats(1'b0),
    .err_acc(err_acc0), .beat_cnt(beat_cnt0));

  assign bus0.in_valid  = bus.in_valid && bus.in_ready;
  assign bus0.in_data   = bus.in_data;
  assign bus0.in_mode   = bus.in_mode;
  assign bus0.out_ready = 1'b1;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int k0_fires = 0;
  bit head_seen = 0;
  bit rand_ph = 0;
  longint m_err = 0;
  longint m_cnt = 0;
  longint last_sum = 0;
  exp_t   q[$];
  longint q0[$];
  int     fire_cycles[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pairwise tree of adjacent operands, each node applying the
  // lower-part rule with plain integer arithmetic.
  function automatic longint model_sum(input logic [N_IN*W-1:0] d, input logic [1:0] m, input int k);
    longint v[N_IN];
    longint x, y, p, lo;
    int n;
    for (int j = 0; j < N_IN; j++) v[j] = longint'(d[j*W +: W]);
    p = longint'(1) << k;
    n = N_IN;
    while (n > 1) begin
      for (int j = 0; j < n/2; j++) begin
        x = v[2*j];
        y = v[2*j+1];
        if (m == 2'b00 || k == 0) begin
          v[j] = x + y;
        end else begin
          case (m)
            2'b01:   lo = (x % p) ^ (y % p);
            2'b10:   lo = (x % p) | (y % p);
            default: lo = 0;
          endcase
          v[j] = (x / p + y / p) * p + lo;
        end
      end
      n = n / 2;
    end
    return v[0];
  endfunction

  function automatic logic [N_IN*W-1:0] rand_data();
    logic [N_IN*W-1:0] d;
    if ($urandom_range(0, 7) == 0) begin
      d = {N_IN{8'hFF}};
    end else begin
      for (int j = 0; j < N_IN; j++) d[j*W +: W] = 8'($urandom_range(0, 255));
    end
    return d;
  endfunction

  // Monitor / scoreboard, sampled 1 ns before each rising edge.
  initial begin
    exp_t e;
    longint e0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        q.delete(); q0.delete();
        m_err = 0; m_cnt = 0; head_seen = 0; k0_fires = 0;
      end else begin
        chk("err_acc", err_acc, m_err);
        chk("beat_cnt", beat_cnt, m_cnt);
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            e = q[0];
            chk("out_sum", bus.out_sum, e.sum);
            chk("out_mode", bus.out_mode, e.mode);
            if (!head_seen) begin
              head_seen = 1;
              if (stall_cnt == e.stalls) chk("latency", cyc - e.acc_cyc, L);
            end
          end
        end
        if (bus.out_valid && !bus.out_ready) stall_cnt++;
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          e = q.pop_front();
          head_seen = 0;
          last_sum = bus.out_sum;
          fire_cycles.push_back(cyc);
          if (clr_stats) begin
            m_err = 0; m_cnt = 0;
          end else begin
            m_err = (m_err + e.exact - e.sum > SAT) ? SAT : m_err + e.exact - e.sum;
            m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
          end
        end else if (clr_stats) begin
          m_err = 0; m_cnt = 0;
        end
        if (bus0.out_valid) begin
          if (q0.size() == 0) begin
            chk("k0_spurious", 1, 0);
          end else begin
            e0 = q0.pop_front();
            chk("k0_sum_exact", bus0.out_sum, e0);
            k0_fires++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e.sum     = model_sum(bus.in_data, bus.in_mode, K);
          e.exact   = model_sum(bus.in_data, 2'b00, K);
          e.mode    = bus.in_mode;
          e.acc_cyc = cyc;
          e.stalls  = stall_cnt;
          q.push_back(e);
          q0.push_back(e.exact);
        end
      end
    end
  end

  // Random backpressure and occasional stats clears during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ph) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        clr_stats     = ($urandom_range(0, 24) == 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [N_IN*W-1:0] d, input logic [1:0] m);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    for (int i = 0; i < 100 && !done; i++) begin
      #4;
      if (bus.in_ready) done = 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 1, 0);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (q.size() == 0 && !bus.out_valid) done = 1;
      else @(negedge clk);
    end
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    logic [N_IN*W-1:0] d7, dff;
    longint t1_exp[4];
    int acc;
    bit seen;
    t1_exp = '{56, 0, 7, 0};
    d7  = {N_IN{8'h07}};
    dff = {N_IN{8'hFF}};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 2'b00; bus.out_ready = 1'b1;

    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err_acc", err_acc, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: all 0x07 in every mode
    for (int m = 0; m < 4; m++) begin
      send(d7, 2'(m));
      drain();
      chk("t1_sum", last_sum, t1_exp[m]);
    end

    // 2: all 0xFF exact, then a lone XOR beat after a clear
    send(dff, 2'b00);
    drain();
    chk("t2_exact_sum", last_sum, 2040);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    send(dff, 2'b01);
    drain();
    chk("t2_xor_sum", last_sum, 1984);
    chk("t2_err_acc", err_acc, 56);
    chk("t2_beat_cnt", beat_cnt, 1);

    // 3: back-to-back modes, results on consecutive cycles
    fire_cycles.delete();
    for (int m = 0; m < 4; m++) send(rand_data(), 2'(m));
    drain();
    chk("t3_count", fire_cycles.size(), 4);
    if (fire_cycles.size() == 4) chk("t3_consecutive", fire_cycles[3] - fire_cycles[0], 3);

    // 4: output stalled, pipe fills after L accepts and holds
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand_data();
      bus.in_mode  = 2'($urandom_range(0, 3));
      #4;
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("t4_accepts", acc, L);
    chk("t4_in_ready", bus.in_ready, 0);
    repeat (5) @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    // 5: reset pulse mid-stream
    for (int i = 0; i < 3; i++) send(rand_data(), 2'($urandom_range(0, 3)));
    chk("t5_pre_valid", bus.out_valid, 1);
    rst = 1'b0;
    #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    chk("t5_err_acc", err_acc, 0);
    chk("t5_beat_cnt", beat_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    send(rand_data(), 2'b01);
    drain();

    // 6: clear coinciding with an accepted XOR result
    send(dff, 2'b01);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.out_valid) seen = 1;
      else @(negedge clk);
    end
    chk("t6_seen_out", seen, 1);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("t6_err_acc", err_acc, 0);
    chk("t6_beat_cnt", beat_cnt, 0);

    // Random phase with backpressure
    rand_ph = 1;
    for (int i = 0; i < 200; i++) send(rand_data(), 2'($urandom_range(0, 3)));
    rand_ph = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    clr_stats = 1'b0;
    drain();
    repeat (L + 2) @(negedge clk);

    // K=0 build: every mode exact, no error accumulated
    chk("k0_err_acc", err_acc0, 0);
    chk("k0_beat_cnt", beat_cnt0, k0_fires);
    chk("k0_queue_empty", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
